digit_serial_addsub: RTL and testbench
======================================

// Module: digit_serial_addsub
// PURPOSE
//   Parametrised, multi-cycle add/subtract unit: the next generation of the 4-bit ripple adder.
//   WIDTH-bit operands are processed DIGIT bits per clock, trading latency for area in small tiles.
//   Adds subtract mode, carry/overflow/zero flags, and valid/ready handshakes on both sides.
//   Sits between the tile I/O operand registers and the result mux in the top-level wrapper.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be >= 1
//   DIGIT  4   bits per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0; N = WIDTH/DIGIT
// PORTS
//   clk        in   1      clock; all state updates on the rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   in_valid   in   1      operand request
//   in_ready   out  1      unit can accept operands (high only in IDLE)
//   sub        in   1      0 = a+b, 1 = a-b; sampled at accept
//   a          in   WIDTH  operand A; sampled at accept
//   b          in   WIDTH  operand B; sampled at accept
//   out_valid  out  1      result and flags valid (high only in DONE)
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  sum or difference, modulo 2^WIDTH
//   carry      out  1      add: carry out; sub: 1 = no borrow (a >= b unsigned)
//   overflow   out  1      two's-complement signed overflow
//   zero       out  1      result == 0
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, counter=0; result, carry, overflow, zero all 0;
//     out_valid=0; in_ready=1 while in reset and after release.
//   FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//   IDLE: accept occurs when in_valid & in_ready at a clock edge. At accept:
//     latch a, and b (or ~b when sub=1); set carry-in = sub; counter=0; go to RUN.
//   RUN: each edge adds the low DIGIT bits of the operand shift registers plus the carry.
//     Shift the DIGIT sum bits into result from the MSB end; shift the operands right by DIGIT.
//     Keep the carry; counter++. On the edge where counter==N-1, go to DONE.
//   Latency: accept at edge E -> out_valid high from edge E+N. N=1 (DIGIT=WIDTH) gives 1-cycle latency.
//   Flags, registered on entering DONE:
//     carry    = final carry out of the MSB.
//     overflow = carry into MSB XOR carry out of MSB.
//     zero     = (final result == 0).
//   DONE: result and flags held stable while out_valid=1 and out_ready=0 (unbounded backpressure).
//     out_valid & out_ready at an edge -> IDLE.
//   After handshake: result and flags keep their last values until the next accept.
//     They are not cleared. result may show partial sums only during RUN.
//   in_valid/inputs while not IDLE: ignored, no queueing. No accept in the same edge as DONE->IDLE.
//     Back-to-back throughput is therefore 1 operation per N+2 cycles minimum.
//   out_ready while not DONE: ignored.
//   sub=1 computes a + ~b + 1; carry=1 means no borrow.
//   Reset mid-RUN or mid-DONE: operation discarded immediately; outputs return to reset values.
//   No X propagation: all registers are reset, including the operand shift registers.
// TESTING
//   (WIDTH=16, DIGIT=4)
//   T1: add 0x1234+0x0FFF, out_ready=1 -> out_valid at E+4; result=0x2233, carry=0, overflow=0, zero=0.
//   T2: add 0xFFFF+0x0001 -> result=0x0000, carry=1, overflow=0, zero=1.
//   T3: add 0x7FFF+0x0001 -> result=0x8000, overflow=1, carry=0.
//       sub 0x8000-0x0001 -> result=0x7FFF, overflow=1, carry=1.
//   T4: sub 0x0003-0x0005 -> result=0xFFFE, carry=0; sub 0x0005-0x0005 -> result=0, carry=1, zero=1.
//   T5: hold out_ready=0 for 10 cycles after out_valid, toggling in_valid/a/b ->
//       result/flags stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
//   T6: assert rst_n=0 two cycles after accept -> immediately out_valid=0, in_ready=1, result=0.
//       Repeat T1 with WIDTH=DIGIT=8, 0xFF+0x01 -> out_valid at E+1, result=0x00, carry=1.

Source files
------------

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: multi-cycle add/subtract unit that processes WIDTH-bit
// operands DIGIT bits per clock (N = WIDTH/DIGIT cycles per operation).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only while idle
//   sub, a, b             operation select and operands, sampled at accept
//   out_valid / out_ready result handshake; out_valid is high only while done
//   result                sum or difference, modulo 2^WIDTH
//   carry                 add: carry out; sub: 1 = no borrow (a >= b unsigned)
//   overflow              two's-complement signed overflow
//   zero                  result == 0
module digit_serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SUM_W = DIGIT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cy;

  logic [SUM_W-1:0] dsum_c;
  logic [WIDTH-1:0] result_step_c;
  logic             msb_cin_c;
  logic             last_c;

  // One digit of the ripple: low DIGIT bits of both operands plus running carry.
  // The new digit enters result at the MSB end so that after N steps the
  // first (least significant) digit has been shifted down to bit 0.
  always_comb begin
    dsum_c        = SUM_W'(op_a[DIGIT-1:0]) + SUM_W'(op_b[DIGIT-1:0]) + SUM_W'(cy);
    result_step_c = (WIDTH'(dsum_c[DIGIT-1:0]) << (WIDTH - DIGIT)) | (result >> DIGIT);
    // Carry into the top bit of this digit, recovered from the sum bit.
    msb_cin_c     = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dsum_c[DIGIT-1];
    last_c        = (cnt == CNT_W'(N - 1));
  end

  // Control, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      cy        <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the accept.
          if (in_valid) begin
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            cy       <= sub;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end

        RUN: begin
          result <= result_step_c;
          op_a   <= op_a >> DIGIT;
          op_b   <= op_b >> DIGIT;
          cy     <= dsum_c[DIGIT];
          cnt    <= cnt + CNT_W'(1);
          if (last_c) begin
            state     <= DONE;
            out_valid <= 1'b1;
            carry     <= dsum_c[DIGIT];
            overflow  <= msb_cin_c ^ dsum_c[DIGIT];
            zero      <= (result_step_c == '0);
          end
        end

        DONE: begin
          // Result and flags hold until consumed; no accept on this edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // 16-bit / 4-bit digit instance
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        carry, overflow, zero;

  // 8-bit single-digit instance
  logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, result8;
  logic        carry8, overflow8, zero8;

  int n_checks = 0;
  int n_errors = 0;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero)
  );

  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .sub(sub8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .carry(carry8), .overflow(overflow8), .zero(zero8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  task automatic model(input int unsigned w, input logic [31:0] x, input logic [31:0] y,
                       input logic s, output logic [31:0] r, output logic c,
                       output logic o, output logic z);
    longint unsigned mask, xs, ys, full;
    logic sx, sy, sr;
    mask = (64'd1 << w) - 64'd1;
    xs = {32'd0, x} & mask;
    ys = {32'd0, y} & mask;
    if (s) begin
      full = (xs - ys) & mask;
      c    = (xs >= ys);
    end else begin
      full = xs + ys;
      c    = ((full >> w) & 64'd1) != 0;
    end
    r  = 32'(full & mask);
    sx = ((xs >> (w - 1)) & 64'd1) != 0;
    sy = ((ys >> (w - 1)) & 64'd1) != 0;
    sr = ((({32'd0, r}) >> (w - 1)) & 64'd1) != 0;
    o  = s ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
    z  = (r == 32'd0);
  endtask

  // One 16-bit operation; hold = cycles of backpressure in DONE, rdy_early
  // keeps out_ready high from before accept (must only be used with hold==0).
  task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic s,
                       input int hold, input logic rdy_early);
    logic [31:0] er;
    logic ec, eo, ez;
    int lat;
    model(16, {16'd0, x}, {16'd0, y}, s, er, ec, eo, ez);
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = x; b = y; sub = s; in_valid = 1'b1; out_ready = rdy_early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency16", lat, 4);
    check("result16", {16'd0, result}, er);
    check("carry16", {31'd0, carry}, {31'd0, ec});
    check("overflow16", {31'd0, overflow}, {31'd0, eo});
    check("zero16", {31'd0, zero}, {31'd0, ez});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_result", {16'd0, result}, er);
      check("hold_flags", {29'd0, carry, overflow, zero}, {29'd0, ec, eo, ez});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_result", {16'd0, result}, er);
    check("post_flags", {29'd0, carry, overflow, zero}, {29'd0, ec, eo, ez});
    out_ready = 1'b0;
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [31:0] er;
    logic ec, eo, ez;
    int lat;
    model(8, {24'd0, x}, {24'd0, y}, s, er, ec, eo, ez);
    @(negedge clk);
    a8 = x; b8 = y; sub8 = s; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency8", lat, 1);
    check("result8", {24'd0, result8}, er);
    check("flags8", {29'd0, carry8, overflow8, zero8}, {29'd0, ec, eo, ez});
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    check("post_valid8", {31'd0, out_valid8}, 32'd0);
    check("post_in_ready8", {31'd0, in_ready8}, 32'd1);
    out_ready8 = 1'b0;
  endtask

  initial begin
    in_valid = 0; sub = 0; a = '0; b = '0; out_ready = 0;
    in_valid8 = 0; sub8 = 0; a8 = '0; b8 = '0; out_ready8 = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {29'd0, carry, overflow, zero}, 32'd0);
    check("rst_out_valid8", {31'd0, out_valid8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run16(16'h1234, 16'h0FFF, 1'b0, 0, 1'b1);
    run16(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run16(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run16(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
    run16(16'h0003, 16'h0005, 1'b1, 0, 1'b0);
    run16(16'h0005, 16'h0005, 1'b1, 0, 1'b0);
    run16(16'hA5A5, 16'h5A5B, 1'b0, 10, 1'b0);

    // Randomized operations with random backpressure
    for (int i = 0; i < 40; i++) begin
      int h;
      h = int'($urandom_range(0, 3));
      run16(16'($urandom), 16'($urandom), 1'($urandom), h, (h == 0) ? 1'($urandom) : 1'b0);
    end

    // Single-cycle configuration
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'h7F, 8'h01, 1'b0);
    run8(8'h10, 8'h20, 1'b1);
    for (int i = 0; i < 10; i++) run8(8'($urandom), 8'($urandom), 1'($urandom));

    // Reset two cycles into an operation
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_result", {16'd0, result}, 32'd0);
    check("midrst_flags", {29'd0, carry, overflow, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run16(16'h1234, 16'h0FFF, 1'b0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
